mem_stall_ctrl: RTL and testbench

Single-port memory access sequencer that sits upstream of the pipeline control unit and generates its external `pause` input. Each pipeline cycle it serialises the MEM-stage data access and the IF-stage instruction fetch onto one shared bus. It holds the pipeline paused until both accesses complete. It then releases the pipeline for exactly one cycle with the read data held stable. A wait-cycle timeout prevents a dead slave from hanging the core.

---
 rtl/mem_stall_ctrl_pkg.sv | 8 +
 rtl/mem_stall_ctrl_bus_wait_timer.sv | 20 ++
 rtl/mem_stall_ctrl.sv | 127 ++++++++++++
 tb/tb_mem_stall_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mem_stall_ctrl_pkg.sv
// mem_stall_ctrl_pkg: shared CPU constants for the memory access sequencer
package mem_stall_ctrl_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_INST = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;
  localparam logic [3:0] FETCH_BE = 4'hF;
endpackage

// File: rtl/mem_stall_ctrl_bus_wait_timer.sv
// bus_wait_timer: per-access bus wait counter with abort flag
// clk/rst_n: clock, sync active-low reset; clr: restart at 0; en: count one wait cycle;
// expire_o: counter sits at WAIT_MAX-1, so one more wait cycle aborts the access
module bus_wait_timer #(
  parameter int WAIT_MAX = 16,
  parameter int CNT_W    = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : en ? cnt_q + CNT_W'(1) : cnt_q;
  always_ff @(posedge clk)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  assign expire_o = cnt_q == CNT_W'(WAIT_MAX - 1);
endmodule

// File: rtl/mem_stall_ctrl.sv
// mem_stall_ctrl: serialises MEM data access then IF fetch onto one bus and pauses the pipeline
// if_*: fetch request/address/instruction; mem_*: load/store request, data; bus_*: registered
// single-port bus master; pause_o: freezes the pipeline; bus_err_o: one-cycle timeout abort pulse
module mem_stall_ctrl
  import mem_stall_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 16,
  parameter int CNT_W    = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_be_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  output logic [31:0] mem_rdata_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ready_i,
  input  logic [31:0] bus_rdata_i,
  output logic        pause_o,
  output logic        bus_err_o
);
  logic [1:0]  state_q, state_d;
  logic        req_q, req_d, we_q, we_d, err_q, err_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, if_rdata_q, if_rdata_d, mem_rdata_q, mem_rdata_d;
  logic        expire, busy, fin, abort;
  assign busy  = state_q == ST_DATA || state_q == ST_INST;
  assign abort = busy && !bus_ready_i && expire;
  assign fin   = busy && (bus_ready_i || expire);
  bus_wait_timer #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (state_d != state_q),
    .en       (busy && !bus_ready_i),
    .expire_o (expire)
  );
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    we_d        = we_q;
    be_d        = be_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    err_d       = 1'b0;
    case (state_q)
      ST_IDLE:
        if (mem_req_i) begin
          state_d = ST_DATA;
          req_d   = 1'b1;
          we_d    = mem_we_i;
          be_d    = mem_be_i;
          addr_d  = mem_addr_i;
          wdata_d = mem_wdata_i;
        end else if (if_req_i) begin
          state_d = ST_INST;
          req_d   = 1'b1;
          we_d    = 1'b0;
          be_d    = FETCH_BE;
          addr_d  = if_addr_i;
        end
      ST_DATA:
        if (fin) begin
          err_d       = abort;
          mem_rdata_d = abort ? 32'h0 : we_q ? mem_rdata_q : bus_rdata_i;
          // back-to-back fetch keeps bus_req_o asserted across the hand-over
          state_d     = if_req_i ? ST_INST : ST_DONE;
          req_d       = if_req_i;
          if (if_req_i) begin
            we_d   = 1'b0;
            be_d   = FETCH_BE;
            addr_d = if_addr_i;
          end
        end
      ST_INST:
        if (fin) begin
          err_d      = abort;
          if_rdata_d = abort ? 32'h0 : bus_rdata_i;
          state_d    = ST_DONE;
          req_d      = 1'b0;
        end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      be_q        <= 4'h0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      err_q       <= 1'b0;
      if_rdata_q  <= 32'h0;
      mem_rdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      we_q        <= we_d;
      be_q        <= be_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  // pause is raised already in IDLE so the pipeline never advances past an unserviced request
  assign pause_o     = rst_n && (busy || (state_q == ST_IDLE && (if_req_i || mem_req_i)));
  assign bus_req_o   = req_q;
  assign bus_we_o    = we_q;
  assign bus_be_o    = be_q;
  assign bus_addr_o  = addr_q;
  assign bus_wdata_o = wdata_q;
  assign bus_err_o   = err_q;
  assign if_rdata_o  = if_rdata_q;
  assign mem_rdata_o = mem_rdata_q;
endmodule

// File: tb/tb_mem_stall_ctrl.sv
// tb_mem_stall_ctrl: directed scoreboard bench for mem_stall_ctrl
module tb_mem_stall_ctrl;
  localparam int P = 0, REQ = 1, ADDR = 2, WE = 3, BE = 4, ERR = 5, MRD = 6, IRD = 7, WD = 8;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        if_req_i = 1'b0, mem_req_i = 1'b0, mem_we_i = 1'b0;
  logic [31:0] if_addr_i = '0, mem_addr_i = '0, mem_wdata_i = '0;
  logic [3:0]  mem_be_i = '0;
  logic [31:0] if_rdata_o, mem_rdata_o, bus_addr_o, bus_wdata_o, bus_rdata_i;
  logic        bus_req_o, bus_we_o, bus_ready_i, pause_o, bus_err_o;
  logic [3:0]  bus_be_o;
  int          slave_wait = 0;
  logic        slave_never = 1'b0;
  int          wcnt = 0;
  int          nchk = 0, nerr = 0;
  typedef struct {string tag; int sel; logic [31:0] v;} exp_t;
  exp_t        exp_q[$];

  always #5 clk = ~clk;

  mem_stall_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_be_i(mem_be_i),
    .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_be_o(bus_be_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .bus_ready_i(bus_ready_i), .bus_rdata_i(bus_rdata_i),
    .pause_o(pause_o), .bus_err_o(bus_err_o)
  );

  // slave: ready after slave_wait stalled cycles of an asserted request
  assign bus_ready_i = bus_req_o && !slave_never && wcnt >= slave_wait;
  assign bus_rdata_i = bus_addr_o == 32'h100 ? 32'hDEADBEEF :
                       bus_addr_o == 32'h400 ? 32'h24020001 : ~bus_addr_o;
  always @(posedge clk)
    if (!rst_n || !bus_req_o || bus_ready_i) wcnt <= 0;
    else wcnt <= wcnt + 1;

  function automatic logic [31:0] obs(int sel);
    case (sel)
      P:       return {31'h0, pause_o};
      REQ:     return {31'h0, bus_req_o};
      ADDR:    return bus_addr_o;
      WE:      return {31'h0, bus_we_o};
      BE:      return {28'h0, bus_be_o};
      ERR:     return {31'h0, bus_err_o};
      MRD:     return mem_rdata_o;
      IRD:     return if_rdata_o;
      default: return bus_wdata_o;
    endcase
  endfunction

  task automatic chk(string tag, int sel, logic [31:0] v);
    exp_q.push_back('{tag, sel, v});
  endtask

  task automatic cyc();
    exp_t e;
    logic [31:0] o;
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs(e.sel);
      nchk++;
      assert (o === e.v) else begin
        nerr++;
        $error("FAIL %s: observed %h expected %h", e.tag, o, e.v);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    @(posedge clk); #1;
    chk("rst_pause", P, 0); chk("rst_req", REQ, 0); chk("rst_addr", ADDR, 0);
    chk("rst_we", WE, 0); chk("rst_be", BE, 0); chk("rst_err", ERR, 0);
    chk("rst_mrd", MRD, 0); chk("rst_ird", IRD, 0); chk("rst_wd", WD, 0);
    cyc();
    rst_n = 1'b1;
    chk("idle_pause", P, 0);
    cyc();
    // 1: load + fetch, zero-wait slave
    mem_req_i = 1; mem_we_i = 0; mem_be_i = 4'hF; mem_addr_i = 32'h100;
    if_req_i = 1; if_addr_i = 32'h400;
    chk("t1_idle_pause", P, 1); chk("t1_idle_req", REQ, 0);
    cyc();
    chk("t1_data_pause", P, 1); chk("t1_data_req", REQ, 1);
    chk("t1_data_addr", ADDR, 32'h100); chk("t1_data_we", WE, 0);
    cyc();
    chk("t1_inst_pause", P, 1); chk("t1_inst_req", REQ, 1);
    chk("t1_inst_addr", ADDR, 32'h400); chk("t1_inst_mrd", MRD, 32'hDEADBEEF);
    cyc();
    mem_req_i = 0; if_req_i = 0;
    chk("t1_done_pause", P, 0); chk("t1_done_req", REQ, 0);
    chk("t1_done_mrd", MRD, 32'hDEADBEEF); chk("t1_done_ird", IRD, 32'h24020001);
    cyc();
    chk("t1_idle2_pause", P, 0);
    cyc();
    // 2: fetch only, 3 wait cycles
    slave_wait = 3; if_req_i = 1; if_addr_i = 32'h400;
    chk("t2_idle_pause", P, 1);
    cyc();
    for (int i = 0; i < 4; i++) begin
      chk("t2_inst_pause", P, 1); chk("t2_inst_req", REQ, 1);
      chk("t2_inst_we", WE, 0); chk("t2_inst_be", BE, 4'hF);
      cyc();
    end
    if_req_i = 0;
    chk("t2_done_pause", P, 0); chk("t2_done_req", REQ, 0);
    cyc();
    // 3: store + fetch
    slave_wait = 0;
    mem_req_i = 1; mem_we_i = 1; mem_be_i = 4'b0011; mem_addr_i = 32'h200; mem_wdata_i = 32'h12345678;
    if_req_i = 1; if_addr_i = 32'h404;
    chk("t3_idle_pause", P, 1);
    cyc();
    chk("t3_data_req", REQ, 1); chk("t3_data_we", WE, 1); chk("t3_data_be", BE, 4'b0011);
    chk("t3_data_addr", ADDR, 32'h200); chk("t3_data_wd", WD, 32'h12345678);
    cyc();
    chk("t3_inst_req", REQ, 1); chk("t3_inst_we", WE, 0); chk("t3_inst_be", BE, 4'hF);
    chk("t3_inst_addr", ADDR, 32'h404); chk("t3_inst_mrd", MRD, 32'hDEADBEEF);
    cyc();
    mem_req_i = 0; if_req_i = 0; mem_we_i = 0;
    chk("t3_done_pause", P, 0); chk("t3_done_mrd", MRD, 32'hDEADBEEF);
    chk("t3_done_ird", IRD, 32'hFFFFFBFB);
    cyc();
    // 4: data access times out after 16 cycles, fetch still served
    slave_never = 1;
    mem_req_i = 1; mem_be_i = 4'hF; mem_addr_i = 32'h300; if_req_i = 1; if_addr_i = 32'h400;
    chk("t4_idle_pause", P, 1);
    cyc();
    for (int i = 0; i < 16; i++) begin
      chk("t4_data_pause", P, 1); chk("t4_data_req", REQ, 1);
      chk("t4_data_err", ERR, 0); chk("t4_data_addr", ADDR, 32'h300);
      cyc();
    end
    slave_never = 0;
    chk("t4_inst_err", ERR, 1); chk("t4_inst_mrd", MRD, 0);
    chk("t4_inst_addr", ADDR, 32'h400); chk("t4_inst_pause", P, 1);
    cyc();
    mem_req_i = 0; if_req_i = 0;
    chk("t4_done_err", ERR, 0); chk("t4_done_pause", P, 0); chk("t4_done_ird", IRD, 32'h24020001);
    cyc();
    // ready on the very cycle the limit is reached: no abort
    slave_wait = 15; if_req_i = 1; if_addr_i = 32'h408;
    cyc();
    for (int i = 0; i < 16; i++) begin
      chk("lim_inst_pause", P, 1); chk("lim_inst_req", REQ, 1);
      cyc();
    end
    if_req_i = 0;
    chk("lim_done_err", ERR, 0); chk("lim_done_ird", IRD, 32'hFFFFFBF7);
    chk("lim_done_pause", P, 0);
    cyc();
    chk("lim_idle_err", ERR, 0);
    cyc();
    // 5: reset mid-fetch with stalled slave
    slave_wait = 0; slave_never = 1; if_req_i = 1; if_addr_i = 32'h400;
    cyc();
    chk("t5_inst_req", REQ, 1);
    cyc();
    rst_n = 0;
    chk("t5_inrst_pause", P, 0);
    cyc();
    chk("t5_rst_req", REQ, 0); chk("t5_rst_addr", ADDR, 0); chk("t5_rst_be", BE, 0);
    chk("t5_rst_mrd", MRD, 0); chk("t5_rst_ird", IRD, 0); chk("t5_rst_err", ERR, 0);
    chk("t5_rst_wd", WD, 0);
    cyc();
    rst_n = 1; slave_never = 0;
    chk("t5_idle_pause", P, 1);
    cyc();
    chk("t5_inst_req2", REQ, 1); chk("t5_inst_addr2", ADDR, 32'h400);
    cyc();
    if_req_i = 0;
    chk("t5_done_pause", P, 0); chk("t5_done_ird", IRD, 32'h24020001);
    cyc();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
